// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router: src, dest, size, data bytes, XOR CRC, with per-byte stall.
// Optional ROUTER_TX_CRC_INJECT_EN adds a crc_inject input that inverts the CRC byte of a packet.
module router_pkt_tx #(
    parameter int         MAX_DATA = 7,
    parameter logic [4:0] SIZE_PAD = 5'b00000
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       pld_wr,
    input  logic [7:0] pld_data,
    input  logic       start,
    input  logic [7:0] src_in,
    input  logic [7:0] dest_in,
    input  logic [2:0] dsize_in,
    input  logic       stall,
`ifdef ROUTER_TX_CRC_INJECT_EN
    input  logic       crc_inject,
`endif
    output logic [7:0] packet_out,
    output logic       packet_valid_o,
    output logic       busy,
    output logic       done,
    output logic       start_err,
    output logic [3:0] pld_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRC,
        S_DEST,
        S_SIZE,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_buf [0:MAX_DATA-1];
    logic [3:0] r_pldCnt;
    logic [7:0] r_src;
    logic [7:0] r_dest;
    logic [2:0] r_dsize;
    logic [2:0] r_rdIdx;
    logic [7:0] r_crcAcc;
    logic       r_startErr;
    logic       w_consume;
    logic       w_idle;
    logic       w_startOk;
    logic       w_startBad;
    logic       w_wrOk;
    logic       w_lastData;
    logic [7:0] w_crcByte;

    assign w_idle     = (r_state == S_IDLE);
    // Start compares against the count before any same-cycle write lands.
    assign w_startOk  = w_idle && start && ({1'b0, dsize_in} <= r_pldCnt);
    assign w_startBad = w_idle && start && ({1'b0, dsize_in} > r_pldCnt);
    assign w_wrOk     = w_idle && pld_wr && (r_pldCnt < 4'(MAX_DATA));
    assign w_consume  = packet_valid_o && !stall;
    assign w_lastData = (r_rdIdx == (r_dsize - 3'd1));

`ifdef ROUTER_TX_CRC_INJECT_EN
    logic r_crcInject;

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_crcInject <= 1'b0;
        end else if (w_startOk) begin
            r_crcInject <= crc_inject;
        end
    end

    assign w_crcByte = r_crcInject ? ~r_crcAcc : r_crcAcc;
`else
    assign w_crcByte = r_crcAcc;
`endif

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (w_startOk) w_nextState = S_SRC;
            S_SRC:  if (w_consume) w_nextState = S_DEST;
            S_DEST: if (w_consume) w_nextState = S_SIZE;
            S_SIZE: if (w_consume) w_nextState = (r_dsize == 3'd0) ? S_CRC : S_DATA;
            S_DATA: if (w_consume && w_lastData) w_nextState = S_CRC;
            S_CRC:  if (w_consume) w_nextState = S_DONE;
            S_DONE: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        packet_out     = 8'h00;
        packet_valid_o = 1'b0;
        done           = 1'b0;
        case (r_state)
            S_SRC: begin
                packet_out     = r_src;
                packet_valid_o = 1'b1;
            end
            S_DEST: begin
                packet_out     = r_dest;
                packet_valid_o = 1'b1;
            end
            S_SIZE: begin
                packet_out     = {SIZE_PAD, r_dsize};
                packet_valid_o = 1'b1;
            end
            S_DATA: begin
                packet_out     = r_buf[r_rdIdx];
                packet_valid_o = 1'b1;
            end
            S_CRC: begin
                packet_out     = w_crcByte;
                packet_valid_o = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_pldCnt   <= 4'd0;
            r_src      <= 8'h00;
            r_dest     <= 8'h00;
            r_dsize    <= 3'd0;
            r_rdIdx    <= 3'd0;
            r_crcAcc   <= 8'h00;
            r_startErr <= 1'b0;
        end else begin
            r_startErr <= w_startBad;
            if (r_state == S_DONE) begin
                r_pldCnt <= 4'd0;
            end else if (w_wrOk) begin
                r_pldCnt <= r_pldCnt + 4'd1;
            end
            if (w_startOk) begin
                r_src    <= src_in;
                r_dest   <= dest_in;
                r_dsize  <= dsize_in;
                r_rdIdx  <= 3'd0;
                r_crcAcc <= 8'h00;
            end else if ((r_state == S_DATA) && w_consume) begin
                r_crcAcc <= r_crcAcc ^ r_buf[r_rdIdx];
                r_rdIdx  <= r_rdIdx + 3'd1;
            end
        end
    end

    // Payload storage has no reset; only bytes below pld_cnt are ever read.
    always_ff @(posedge clk1) begin
        if (w_wrOk) begin
            r_buf[r_pldCnt[2:0]] <= pld_data;
        end
    end

    assign busy      = !w_idle;
    assign start_err = r_startErr;
    assign pld_cnt   = r_pldCnt;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bytes queued at start, compared as the DUT hands them off.
module tb_router_pkt_tx;

    logic       clk1 = 1'b0;
    logic       reset;
    logic       pldWr;
    logic [7:0] pldData;
    logic       start;
    logic [7:0] srcIn;
    logic [7:0] destIn;
    logic [2:0] dsizeIn;
    logic       stall;
`ifdef ROUTER_TX_CRC_INJECT_EN
    logic       crcInject;
`endif
    logic [7:0] packetOut;
    logic       packetValid;
    logic       busy;
    logic       done;
    logic       startErr;
    logic [3:0] pldCnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startCyc = 0;
    int validCnt = 0;
    int doneCnt = 0;
    int modelCnt = 0;
    logic [7:0] modelBuf [0:7];
    logic [7:0] expQ [$];

    router_pkt_tx dut (
        .clk1           (clk1),
        .reset          (reset),
        .pld_wr         (pldWr),
        .pld_data       (pldData),
        .start          (start),
        .src_in         (srcIn),
        .dest_in        (destIn),
        .dsize_in       (dsizeIn),
        .stall          (stall),
`ifdef ROUTER_TX_CRC_INJECT_EN
        .crc_inject     (crcInject),
`endif
        .packet_out     (packetOut),
        .packet_valid_o (packetValid),
        .busy           (busy),
        .done           (done),
        .start_err      (startErr),
        .pld_cnt        (pldCnt)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Bytes handed off at the next rising edge are popped and compared; stalled bytes must match the head.
    always @(negedge clk1) begin
        if (reset) begin
            if (packetValid) validCnt++;
            if (done) doneCnt++;
            if (packetValid && stall) begin
                if (expQ.size() == 0) checkOutput("heldByteNoExpect", 32'(expQ.size()), 1);
                else checkOutput("heldByte", packetOut, expQ[0]);
            end else if (packetValid) begin
                if (expQ.size() == 0) checkOutput("unexpectedByte", 32'(expQ.size()), 1);
                else checkOutput("streamByte", packetOut, expQ.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic loadByte(input logic [7:0] b);
        pldWr   = 1'b1;
        pldData = b;
        if (modelCnt < 7) begin
            modelBuf[modelCnt] = b;
            modelCnt++;
        end
        step();
        pldWr = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] src, input logic [7:0] dest, input logic [2:0] dsize, input bit inject);
        logic [7:0] crc;
        crc = 8'h00;
        expQ.push_back(src);
        expQ.push_back(dest);
        expQ.push_back({5'b00000, dsize});
        for (int i = 0; i < int'(dsize); i++) begin
            expQ.push_back(modelBuf[i]);
            crc ^= modelBuf[i];
        end
        expQ.push_back(inject ? ~crc : crc);
        srcIn   = src;
        destIn  = dest;
        dsizeIn = dsize;
        start   = 1'b1;
`ifdef ROUTER_TX_CRC_INJECT_EN
        crcInject = inject;
`endif
        step();
        start    = 1'b0;
        startCyc = cyc;
        modelCnt = 0;
    endtask

    task automatic waitDone(input int expLatency);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk1);
            if (done) begin
                seen = 1'b1;
                checkOutput("doneLatency", 32'(cyc - startCyc), 32'(expLatency));
                break;
            end
        end
        checkOutput("donePulse", 32'(seen), 1);
        checkOutput("queueDrained", 32'(expQ.size()), 0);
        step();
        checkOutput("pldCntCleared", 32'(pldCnt), 0);
        checkOutput("busyAfterDone", 32'(busy), 0);
        checkOutput("doneOneCycle", 32'(done), 0);
    endtask

    task automatic waitForByte(input logic [7:0] b);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk1);
            if (packetValid && packetOut == b) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("byteSeen", 32'(seen), 1);
    endtask

    initial begin
        int v0;
        int d0;
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int v0;
        int d0;
        reset   = 1'b0;
        pldWr   = 1'b0;
        pldData = 8'h00;
        start   = 1'b0;
        srcIn   = 8'h00;
        destIn  = 8'h00;
        dsizeIn = 3'd0;
        stall   = 1'b0;
`ifdef ROUTER_TX_CRC_INJECT_EN
        crcInject = 1'b0;
`endif
        #1;
        checkOutput("rstPacketOut", packetOut, 0);
        checkOutput("rstValid", 32'(packetValid), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstDone", 32'(done), 0);
        checkOutput("rstStartErr", 32'(startErr), 0);
        checkOutput("rstPldCnt", 32'(pldCnt), 0);
        step();
        step();
        reset = 1'b1;
        step();

        $display("[TB] basic 3-byte packet");
        loadByte(8'h11);
        loadByte(8'h22);
        loadByte(8'h44);
        checkOutput("pldCntLoaded", 32'(pldCnt), 3);
        v0 = validCnt;
        applyStimulus(8'h81, 8'h01, 3'd3, 1'b0);
        checkOutput("busyAfterStart", 32'(busy), 1);
        waitDone(7);
        checkOutput("validCycles", 32'(validCnt - v0), 7);

        $display("[TB] stall on destination byte");
        loadByte(8'h11);
        loadByte(8'h22);
        loadByte(8'h44);
        v0 = validCnt;
        applyStimulus(8'h81, 8'h01, 3'd3, 1'b0);
        waitForByte(8'h81);
        step();
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
        waitDone(9);
        checkOutput("validCyclesStall", 32'(validCnt - v0), 9);

        $display("[TB] zero-length packet");
        applyStimulus(8'h83, 8'h02, 3'd0, 1'b0);
        waitDone(4);

        $display("[TB] rejected start");
        loadByte(8'h5A);
        loadByte(8'hC3);
        v0 = validCnt;
        srcIn   = 8'h99;
        dsizeIn = 3'd5;
        start   = 1'b1;
        step();
        start = 1'b0;
        checkOutput("startErrPulse", 32'(startErr), 1);
        checkOutput("busyAfterReject", 32'(busy), 0);
        step();
        checkOutput("startErrOneCycle", 32'(startErr), 0);
        step();
        checkOutput("rejectValidCycles", 32'(validCnt - v0), 0);
        checkOutput("rejectPldCnt", 32'(pldCnt), 2);

        $display("[TB] start with simultaneous write uses pre-write count");
        pldWr   = 1'b1;
        pldData = 8'h0F;
        modelBuf[modelCnt] = 8'h0F;
        modelCnt++;
        dsizeIn = 3'd3;
        start   = 1'b1;
        step();
        pldWr = 1'b0;
        start = 1'b0;
        checkOutput("simulStartErr", 32'(startErr), 1);
        checkOutput("simulPldCnt", 32'(pldCnt), 3);
        applyStimulus(8'h84, 8'h03, 3'd3, 1'b0);
        waitDone(7);

        $display("[TB] full buffer, overflow write and busy pokes");
        for (int i = 0; i < 8; i++) loadByte(8'(1 << i));
        checkOutput("pldCntFull", 32'(pldCnt), 7);
        applyStimulus(8'h85, 8'h04, 3'd7, 1'b0);
        step();
        start   = 1'b1;
        dsizeIn = 3'd0;
        pldWr   = 1'b1;
        pldData = 8'hEE;
        step();
        start = 1'b0;
        pldWr = 1'b0;
        checkOutput("busyStartNoErr", 32'(startErr), 0);
        checkOutput("busyWriteIgnored", 32'(pldCnt), 7);
        waitDone(11);

        $display("[TB] reset during data");
        loadByte(8'h11);
        loadByte(8'h22);
        loadByte(8'h44);
        d0 = doneCnt;
        applyStimulus(8'h81, 8'h01, 3'd3, 1'b0);
        waitForByte(8'h11);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncRstValid", 32'(packetValid), 0);
        checkOutput("asyncRstBusy", 32'(busy), 0);
        checkOutput("asyncRstPldCnt", 32'(pldCnt), 0);
        expQ.delete();
        modelCnt = 0;
        step();
        step();
        reset = 1'b1;
        step();
        checkOutput("noDoneAfterAbort", 32'(doneCnt - d0), 0);
        loadByte(8'h10);
        loadByte(8'h32);
        applyStimulus(8'h86, 8'h05, 3'd2, 1'b0);
        waitDone(6);

`ifdef ROUTER_TX_CRC_INJECT_EN
        $display("[TB] CRC inject");
        loadByte(8'hAA);
        applyStimulus(8'h87, 8'h06, 3'd1, 1'b1);
        waitDone(5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
